// File: rtl/gpio_in_responder.sv
// gpio_in_responder: synchronised, debounced GPIO inputs with sticky edge flags and a level IRQ,
// exposed as four word registers on the PicoRV32 native memory bus.
module gpio_in_responder #(
  parameter int          WIDTH           = 8,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0300_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, sync, deb, flip, edge_q, edge_n, irq_en, irq_en_n, clr, wmask;
  logic [WIDTH-1:0] pend_wdata;
  logic [31:0] rd_val, strb_mask;
  logic [3:0] pend_wstrb;
  logic [1:0] pend_off;
  logic sel, pend_wr, unused_ok;
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync, s1} <= '0;
    else {sync, s1} <= {s1, pins};
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic d;
    assign flip[i] = (sync[i] != d) && (cnt == CNT_MAX);
    assign deb[i] = d;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        d <= 1'b0;
      end else begin
        cnt <= (sync[i] == d || flip[i]) ? '0 : cnt + CW'(1);
        d <= d ^ flip[i];
      end
  end
  assign sel = mem_valid && mem_addr[31:4] == BASE_ADDR[31:4] && !mem_ready;
  assign rd_val = mem_addr[3:2] == 2'd0 ? 32'(deb) :
                  mem_addr[3:2] == 2'd1 ? 32'(edge_q) :
                  mem_addr[3:2] == 2'd2 ? 32'(irq_en) : 32'(sync);
  // A write is captured at select and takes effect on the following edge, as mem_ready falls
  assign strb_mask = {{8{pend_wstrb[3]}}, {8{pend_wstrb[2]}}, {8{pend_wstrb[1]}}, {8{pend_wstrb[0]}}};
  assign wmask = strb_mask[WIDTH-1:0];
  assign clr = (pend_wr && pend_off == 2'd1) ? pend_wdata & wmask : '0;
  assign edge_n = (edge_q & ~clr) | flip;
  assign irq_en_n = (pend_wr && pend_off == 2'd2) ? (irq_en & ~wmask) | (pend_wdata & wmask) : irq_en;
  assign unused_ok = ^{mem_addr[1:0], mem_wdata, strb_mask};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      edge_q <= '0;
      irq_en <= '0;
      irq <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      pend_wr <= 1'b0;
      pend_off <= '0;
      pend_wdata <= '0;
      pend_wstrb <= '0;
    end else begin
      edge_q <= edge_n;
      irq_en <= irq_en_n;
      irq <= |(edge_q & irq_en);
      mem_ready <= sel;
      mem_rdata <= (sel && mem_wstrb == 4'd0) ? rd_val : '0;
      pend_wr <= sel && mem_wstrb != 4'd0;
      if (sel) begin
        pend_off <= mem_addr[3:2];
        pend_wdata <= mem_wdata[WIDTH-1:0];
        pend_wstrb <= mem_wstrb;
      end
    end
endmodule

// File: tb/tb_gpio_in_responder.sv
// tb_gpio_in_responder: scoreboard bench; reference model decides debounce from a window of pin history.
module tb_gpio_in_responder;
  localparam int D = 16;
  localparam logic [31:0] BASE = 32'h0300_0000;
  logic clk = 1'b0;
  logic reset, mem_valid, mem_ready, irq;
  logic [7:0] pins;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  int checks = 0, fails = 0;
  logic [31:0] exp_q[$];
  bit [7:0] m_deb, m_edge, m_en;
  bit [7:0] h [0:D];
  bit m_irq, apply_wr;
  bit [1:0] pw_off;
  bit [31:0] pw_data;
  bit [3:0] pw_strb;

  always #5 clk = ~clk;

  gpio_in_responder #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .pins(pins), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .irq(irq)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_deb = 0;
    m_edge = 0;
    m_en = 0;
    m_irq = 0;
    apply_wr = 0;
    foreach (h[k]) h[k] = 0;
  endtask

  // h[k] holds the pin sample taken k edges ago; a bit flips once its last D synchronised samples all differ
  task automatic tick();
    bit [7:0] p, flip, clr, msk;
    bit rn, ni;
    p = pins;
    rn = reset;
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 8; i++) begin
        flip[i] = 1'b1;
        for (int k = 1; k <= D; k++) if (h[k][i] == m_deb[i]) flip[i] = 1'b0;
      end
      clr = 0;
      ni = |(m_edge & m_en);
      if (apply_wr) begin
        msk = pw_strb[0] ? 8'hFF : 8'h00;
        if (pw_off == 2'd1) clr = pw_data[7:0] & msk;
        if (pw_off == 2'd2) m_en = (m_en & ~msk) | (pw_data[7:0] & msk);
        apply_wr = 0;
      end
      m_edge = (m_edge & ~clr) | flip;
      m_deb = m_deb ^ flip;
      m_irq = ni;
      for (int k = D; k > 0; k--) h[k] = h[k-1];
      h[0] = p;
    end
    #1;
  endtask

  function automatic logic [31:0] mreg(input logic [1:0] o);
    return o == 2'd0 ? 32'(m_deb) : o == 2'd1 ? 32'(m_edge) : o == 2'd2 ? 32'(m_en) : 32'(h[1]);
  endfunction

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] e);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    exp_q.push_back(s != 4'd0 ? 32'd0 : e);
    tick();
    chk("ready_rise", mem_ready, 1);
    if (s != 4'd0) begin
      apply_wr = 1;
      pw_off = a[3:2];
      pw_data = d;
      pw_strb = s;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    tick();
    chk("ready_fall", mem_ready, 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    bus(a, 32'd0, 4'd0, e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(a, d, s, 32'd0);
  endtask

  task automatic do_reset(input logic [7:0] pv);
    reset = 1'b1;
    pins = pv;
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    model_reset();
    repeat (3) tick();
    chk("rst_ready", mem_ready, 0);
    chk("rst_irq", irq, 0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rdata", mem_rdata, exp_q.pop_front());
    end
    if (reset === 1'b0) chk("irq", irq, m_irq);
  end

  initial begin
    bit seen;
    int op;
    logic [7:0] b;
    logic [31:0] a;
    mem_addr = BASE;
    mem_wdata = 32'd0;
    do_reset(8'hFF);
    repeat (D + 1) tick();
    rd(BASE, 32'h00);
    rd(BASE, 32'hFF);
    rd(BASE + 4, 32'hFF);
    wr(BASE + 4, 32'hFF, 4'hF);
    rd(BASE + 4, 32'h00);
    // glitch rejection, then exact rise latency
    do_reset(8'h00);
    pins[0] = 1'b1;
    repeat (10) tick();
    pins[0] = 1'b0;
    repeat (30) tick();
    rd(BASE, 32'h00);
    rd(BASE + 4, 32'h00);
    pins[0] = 1'b1;
    repeat (D + 2) tick();
    rd(BASE, 32'h01);
    pins[0] = 1'b0;
    repeat (25) tick();
    wr(BASE + 4, 32'hFF, 4'hF);
    wr(BASE + 8, 32'h01, 4'hF);
    pins[0] = 1'b1;
    repeat (D + 2) tick();
    chk("irq_pre", irq, 0);
    tick();
    chk("irq_rise", irq, 1);
    wr(BASE + 4, 32'h01, 4'hF);
    chk("irq_hold", irq, 1);
    tick();
    chk("irq_clear", irq, 0);
    pins[1] = 1'b1;
    repeat (25) tick();
    rd(BASE + 4, 32'h02);
    chk("irq_masked", irq, 0);
    // clear of bit 2 lands on the same edge as its debounced toggle
    pins[2] = 1'b1;
    repeat (D) tick();
    wr(BASE + 4, 32'h04, 4'hF);
    rd(BASE + 4, 32'h06);
    wr(BASE + 4, 32'h04, 4'hF);
    rd(BASE + 4, 32'h02);
    rd(BASE + 12, 32'h07);
    rd(BASE + 3, 32'h07);
    wr(BASE + 8, 32'h0, 4'hF);
    wr(BASE + 8, 32'hFFFF_FFFF, 4'b0010);
    rd(BASE + 8, 32'h00);
    wr(BASE + 8, 32'hFFFF_FF5A, 4'b0001);
    rd(BASE + 8, 32'h5A);
    mem_valid = 1'b1;
    mem_addr = BASE + 32'h10;
    mem_wstrb = 4'd0;
    seen = 0;
    repeat (20) begin
      tick();
      seen |= mem_ready;
    end
    mem_valid = 1'b0;
    chk("oow_silent", seen, 0);
    mem_addr = BASE;
    mem_valid = 1'b1;
    reset = 1'b1;
    model_reset();
    seen = 0;
    repeat (3) begin
      tick();
      seen |= mem_ready;
    end
    mem_valid = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      tick();
      seen |= mem_ready;
    end
    chk("rst_abort", seen, 0);
    rd(BASE, 32'h00);
    repeat (300) begin
      op = $urandom_range(0, 9);
      b = 8'd1 << $urandom_range(0, 7);
      a = BASE | 32'($urandom_range(0, 15));
      if (op < 3) pins = pins ^ b;
      else if (op == 3) begin
        pins = pins ^ b;
        repeat ($urandom_range(1, D - 1)) tick();
        pins = pins ^ b;
      end
      else if (op < 7) rd(a, mreg(a[3:2]));
      else wr(a, $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
